sdhci_cmd_engine: RTL
=====================

// Module: sdhci_cmd_engine
// PURPOSE
// SD-bus command-line engine downstream of the SDHCI register file: consumes command fields
// (index, argument, response type, clock divider) and generates the SD card clock.
// Serialises the 48-bit command frame with CRC7 onto CMD, then captures and checks the card response.
// Reports status back to the register file (hw2reg) via done/error/response outputs.
// PARAMETERS
// NcrMax    64  max SD clocks from command end bit to response start bit before timeout
// NccCycles 8   SD clocks idle gap after a transaction before busy_o drops
// PORTS
// clk_i          in   1    system clock
// rst_ni         in   1    asynchronous reset, active low
// clk_en_i       in   1    1: sd_clk_o runs; 0: sd_clk_o holds, FSM frozen
// clk_div_i      in   8    sd_clk period = 2*(clk_div_i+1) clk_i cycles
// start_i        in   1    one-cycle pulse: launch a command (ignored while busy_o)
// cmd_index_i    in   6    command index
// cmd_arg_i      in   32   command argument
// resp_type_i    in   2    0 none, 1 R1 (48b, CRC+index check), 2 R2 (136b), 3 R3 (48b, no checks)
// sd_clk_o       out  1    SD card clock
// sd_cmd_o       out  1    CMD output data
// sd_cmd_oe_o    out  1    CMD output enable
// sd_cmd_i       in   1    CMD input (already synchronised by the pad ring)
// busy_o         out  1    transaction in progress
// done_o         out  1    one-cycle pulse at transaction end
// resp_o         out  120  R1/R3: bits 39:8 in [31:0], upper 0; R2: bits 127:8
// err_timeout_o  out  1    no response start bit within NcrMax
// err_crc_o      out  1    CRC7 mismatch (R1, R2)
// err_end_bit_o  out  1    response end bit was 0
// err_index_o    out  1    R1 index != cmd_index_i, or transmission bit != 0
// BEHAVIOUR
// - Reset: sd_clk_o=0, sd_cmd_o=1, sd_cmd_oe_o=0, busy_o=0, done_o=0, resp_o=0, all err_*=0,
//   divider counter=0, FSM=IDLE; assertion mid-transaction aborts immediately.
// - Clock: counter runs while clk_en_i; on reaching clk_div_i it reloads 0 and toggles sd_clk_o.
//   A changed clk_div_i applies at the next reload. "fall"/"rise" = cycle sd_clk_o toggles low/high.
// - CMD changes only on fall; sd_cmd_i sampled only on rise. Every FSM transition except
//   IDLE->TX happens on a fall or rise; with clk_en_i=0 the FSM holds its state.
// - start_i in IDLE: latch index/arg/type, clear err_* and resp_o, busy_o=1 next cycle, enter TX.
//   start_i while busy_o=1: ignored, no state change.
// - TX: frame = 0,1,index[5:0],arg[31:0],CRC7[6:0],1 MSB first; sd_cmd_oe_o=1 from first fall
//   to the fall after the end bit. CRC7 poly x^7+x^3+1, init 0, over first 40 bits.
//   After end bit: type 0 -> GAP, else WAIT.
// - WAIT: oe=0, sd_cmd_o=1. First rise sampling 0 -> RX (start bit counts as bit 0).
//   NcrMax rises without a 0 -> err_timeout_o=1, GAP.
// - RX: shift rises until 48 (R1/R3) or 136 (R2) bits total, then check:
//   end bit 1 else err_end_bit_o;
//   R1: bit46=0 and bits45:40==index else err_index_o; CRC7 over bits 47:8 == bits7:1 else err_crc_o.
//   R2: CRC7 over bits 127:8 == bits 7:1 else err_crc_o. R3: checks skipped.
//   resp_o loaded even on error. -> GAP.
// - GAP: NccCycles rises with CMD released; then IDLE, done_o=1 and busy_o=0 in that same cycle.
// - err_* stay valid until the next accepted start_i.
// STRUCTURE
// - sdhci_pkg: resp_type_e, cmd_state_e {IDLE,TX,WAIT,RX,GAP}, Crc7Poly=7'h09, frame lengths 48/136.
// - Sub-module sdhci_crc7: serial CRC7 with clear/enable/data_in/crc_o; one instance,
//   shared between TX and RX (never concurrent).
// - Single bit counter (8b) reused for TX, WAIT timeout, RX, GAP.
// TESTING
// - CMD0 arg 0, type 0, div 0 -> CMD frame 0x400000000095; sd_clk period 2 cycles; done 8 rises after end bit.
// - CMD8 arg 0x000001AA, type 1 -> TX 0x48000001AA87; card replies 0x08000001AA13 -> resp_o[31:0]=0x1AA, no errors.
// - CMD17 type 1, card never drives 0 -> err_timeout_o=1 after 64 rises; done_o pulses; busy_o low.
// - R1 response with one payload bit flipped -> err_crc_o=1; end bit forced 0 -> err_end_bit_o=1.
// - CMD2 type 2, model returns 136-bit CID with valid CRC -> resp_o = bits 127:8, no errors; start_i mid-RX ignored.
// - div 3, clk_en_i low 20 cycles mid-TX -> sd_clk frozen, frame intact; rst_ni low mid-TX -> all outputs at reset values.

Source files
------------

// File: rtl/sdhci_pkg.sv
// Shared types and constants for the SD command-line engine.
package sdhci_pkg;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_R1   = 2'd1,
    RESP_R2   = 2'd2,
    RESP_R3   = 2'd3
  } resp_type_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    TX   = 3'd1,
    WAIT = 3'd2,
    RX   = 3'd3,
    GAP  = 3'd4
  } cmd_state_e;

  localparam logic [6:0] Crc7Poly   = 7'h09;
  localparam logic [7:0] FrameLenR1 = 8'd48;
  localparam logic [7:0] FrameLenR2 = 8'd136;
  localparam logic [7:0] TxCrcPos   = 8'd40;

  // Index of the last response bit for a given response type.
  function automatic logic [7:0] rx_last(input resp_type_e t);
    return (t == RESP_R2) ? (FrameLenR2 - 8'd1) : (FrameLenR1 - 8'd1);
  endfunction

endpackage

// File: rtl/sdhci_crc7.sv
// Serial CRC7 (x^7+x^3+1), MSB-first, shared by the command and response paths.
module sdhci_crc7
  import sdhci_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_i,
  input  logic       en_i,
  input  logic       data_i,
  output logic [6:0] crc_o
);

  logic w_fb;
  assign w_fb = data_i ^ crc_o[6];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crc_o <= '0;
    end else if (clear_i) begin
      crc_o <= '0;
    end else if (en_i) begin
      crc_o <= {crc_o[5:0], 1'b0} ^ ({7{w_fb}} & Crc7Poly);
    end
  end

endmodule

// File: rtl/sdhci_cmd_engine.sv
// SD CMD-line engine: divides the SD clock, sends the 48-bit command frame
// and captures/checks the card response.
module sdhci_cmd_engine
  import sdhci_pkg::*;
#(
  parameter int unsigned NcrMax    = 64,
  parameter int unsigned NccCycles = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clk_en_i,
  input  logic [7:0]   clk_div_i,
  input  logic         start_i,
  input  logic [5:0]   cmd_index_i,
  input  logic [31:0]  cmd_arg_i,
  input  logic [1:0]   resp_type_i,
  output logic         sd_clk_o,
  output logic         sd_cmd_o,
  output logic         sd_cmd_oe_o,
  input  logic         sd_cmd_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [119:0] resp_o,
  output logic         err_timeout_o,
  output logic         err_crc_o,
  output logic         err_end_bit_o,
  output logic         err_index_o
);

  localparam logic [7:0] NcrLast = 8'(NcrMax - 1);
  localparam logic [7:0] NccLast = 8'(NccCycles - 1);

  logic [7:0]   r_div_cnt;
  logic         r_sd_clk;
  cmd_state_e   r_state;
  logic [7:0]   r_bit_cnt;
  logic [135:0] r_sh;
  logic [5:0]   r_idx;
  resp_type_e   r_type;
  logic         r_cmd;
  logic         r_oe;
  logic         r_busy;
  logic         r_done;
  logic [119:0] r_resp;
  logic         r_err_to, r_err_crc, r_err_end, r_err_idx;

  logic         w_tick, w_fall, w_rise;
  logic [135:0] w_rx_sh;
  logic [6:0]   w_crc;
  logic         w_crc_clr, w_crc_en, w_crc_d;

  // >= so that lowering clk_div_i mid-count reloads instead of wrapping.
  assign w_tick  = clk_en_i && (r_div_cnt >= clk_div_i);
  assign w_fall  = w_tick && r_sd_clk;
  assign w_rise  = w_tick && !r_sd_clk;
  assign w_rx_sh = {r_sh[134:0], sd_cmd_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_div_cnt <= '0;
      r_sd_clk  <= 1'b0;
    end else if (clk_en_i) begin
      if (w_tick) begin
        r_div_cnt <= '0;
        r_sd_clk  <= ~r_sd_clk;
      end else begin
        r_div_cnt <= r_div_cnt + 8'd1;
      end
    end
  end

  // CRC feed: first 40 TX bits; R1/R3 response bits 0..39; R2 bits 8..127.
  always_comb begin
    w_crc_clr = 1'b0;
    w_crc_en  = 1'b0;
    w_crc_d   = 1'b0;
    case (r_state)
      IDLE: w_crc_clr = start_i;
      TX: begin
        if (w_fall) begin
          if (r_bit_cnt < TxCrcPos) begin
            w_crc_en = 1'b1;
            w_crc_d  = r_sh[135];
          end else if (r_bit_cnt == FrameLenR1) begin
            w_crc_clr = 1'b1;
          end
        end
      end
      WAIT: begin
        w_crc_en = w_rise && !sd_cmd_i && (r_type != RESP_R2);
        w_crc_d  = sd_cmd_i;
      end
      RX: begin
        w_crc_d = sd_cmd_i;
        if (r_type == RESP_R2)
          w_crc_en = w_rise && (r_bit_cnt >= 8'd8) && (r_bit_cnt < 8'd128);
        else
          w_crc_en = w_rise && (r_bit_cnt < TxCrcPos);
      end
      default: ;
    endcase
  end

  sdhci_crc7 u_crc7 (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (w_crc_clr),
    .en_i    (w_crc_en),
    .data_i  (w_crc_d),
    .crc_o   (w_crc)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_sh      <= '0;
      r_idx     <= '0;
      r_type    <= RESP_NONE;
      r_cmd     <= 1'b1;
      r_oe      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_resp    <= '0;
      r_err_to  <= 1'b0;
      r_err_crc <= 1'b0;
      r_err_end <= 1'b0;
      r_err_idx <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_sh      <= {2'b01, cmd_index_i, cmd_arg_i, 96'b0};
            r_idx     <= cmd_index_i;
            r_type    <= resp_type_e'(resp_type_i);
            r_resp    <= '0;
            r_err_to  <= 1'b0;
            r_err_crc <= 1'b0;
            r_err_end <= 1'b0;
            r_err_idx <= 1'b0;
            r_busy    <= 1'b1;
            r_bit_cnt <= '0;
            r_state   <= TX;
          end
        end
        TX: begin
          if (w_fall) begin
            if (r_bit_cnt == FrameLenR1) begin
              r_oe      <= 1'b0;
              r_cmd     <= 1'b1;
              r_bit_cnt <= '0;
              r_state   <= (r_type == RESP_NONE) ? GAP : WAIT;
            end else begin
              r_oe      <= 1'b1;
              r_bit_cnt <= r_bit_cnt + 8'd1;
              // At bit 40 the CRC is final: send its MSB, queue the rest plus end bit.
              if (r_bit_cnt == TxCrcPos) begin
                r_cmd          <= w_crc[6];
                r_sh[135:128]  <= {w_crc[5:0], 2'b10};
              end else begin
                r_cmd <= r_sh[135];
                r_sh  <= {r_sh[134:0], 1'b0};
              end
            end
          end
        end
        WAIT: begin
          if (w_rise) begin
            if (!sd_cmd_i) begin
              r_sh      <= w_rx_sh;
              r_bit_cnt <= 8'd1;
              r_state   <= RX;
            end else if (r_bit_cnt == NcrLast) begin
              r_err_to  <= 1'b1;
              r_bit_cnt <= '0;
              r_state   <= GAP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 8'd1;
            end
          end
        end
        RX: begin
          if (w_rise) begin
            r_sh <= w_rx_sh;
            if (r_bit_cnt == rx_last(r_type)) begin
              r_err_end <= ~w_rx_sh[0];
              case (r_type)
                RESP_R1: begin
                  r_err_idx <= w_rx_sh[46] | (w_rx_sh[45:40] != r_idx);
                  r_err_crc <= (w_crc != w_rx_sh[7:1]);
                  r_resp    <= {88'b0, w_rx_sh[39:8]};
                end
                RESP_R2: begin
                  r_err_crc <= (w_crc != w_rx_sh[7:1]);
                  r_resp    <= w_rx_sh[127:8];
                end
                default: r_resp <= {88'b0, w_rx_sh[39:8]};
              endcase
              r_bit_cnt <= '0;
              r_state   <= GAP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 8'd1;
            end
          end
        end
        GAP: begin
          if (w_rise) begin
            if (r_bit_cnt == NccLast) begin
              r_bit_cnt <= '0;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_state   <= IDLE;
            end else begin
              r_bit_cnt <= r_bit_cnt + 8'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sd_clk_o      = r_sd_clk;
  assign sd_cmd_o      = r_cmd;
  assign sd_cmd_oe_o   = r_oe;
  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign resp_o        = r_resp;
  assign err_timeout_o = r_err_to;
  assign err_crc_o     = r_err_crc;
  assign err_end_bit_o = r_err_end;
  assign err_index_o   = r_err_idx;

endmodule
